// File: rtl/axi4_stream_reader_v2_pkg.sv
// Shared constants and constant functions for the AXI4-Stream reader.
package axi4_stream_reader_v2_pkg;

  localparam int unsigned MAX_STRB_WIDTH = 128;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // All-ones strobe mask of the given width, right-aligned in a wide vector.
  function automatic logic [MAX_STRB_WIDTH-1:0] strb_all_ones(input int unsigned width);
    logic [MAX_STRB_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_reader_v2_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head entry visible on rd_data_c
// whenever non-empty; reads zero when empty.
module sync_fifo_fwft
  import axi4_stream_reader_v2_pkg::*;
#(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty_c,
  output logic             full_c,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty_c   = (level == '0);
  assign full_c    = (level == LW'(DEPTH));
  assign do_wr     = wr_en & ~full_c;
  assign do_rd     = rd_en & ~empty_c;
  assign rd_data_c = empty_c ? '0 : mem[rd_ptr];

  // Storage carries no reset; emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axi4_stream_reader_v2.sv
// AXI4-Stream slave that buffers beats in a FWFT FIFO for user logic, counts
// delivered packets and flags partial-strobe beats.
module axi4_stream_reader_v2
  import axi4_stream_reader_v2_pkg::*;
#(
  parameter  int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter  int unsigned C_FIFO_DEPTH         = 4,
  parameter  int unsigned C_PKT_CNT_WIDTH      = 16,
  localparam int unsigned LEVEL_W              = clog2(C_FIFO_DEPTH) + 1,
  localparam int unsigned STRB_W               = C_S_AXIS_TDATA_WIDTH / 8
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [STRB_W-1:0]               S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data,
  output logic                            data_valid,
  output logic                            data_last,
  input  logic                            ready,
  output logic [LEVEL_W-1:0]              level,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_count,
  output logic                            strb_error,
  input  logic                            clear
);

  localparam int unsigned       ENTRY_W   = C_S_AXIS_TDATA_WIDTH + 1;
  localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_all_ones(STRB_W));

  logic               rst_q;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Holds TREADY low until the first clock after reset release.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) rst_q <= 1'b0;
    else                 rst_q <= 1'b1;
  end

  assign S_AXIS_TREADY     = rst_q & ~fifo_full;
  assign push              = S_AXIS_TVALID & S_AXIS_TREADY;
  assign data_valid        = ~fifo_empty;
  assign pop               = data_valid & ready;
  assign {data_last, data} = head;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk       (S_AXIS_ACLK),
    .rst_n     (S_AXIS_ARESETN),
    .wr_en     (push),
    .wr_data   ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .rd_en     (pop),
    .rd_data_c (head),
    .empty_c   (fifo_empty),
    .full_c    (fifo_full),
    .level     (level)
  );

  // Delivered-packet counter; clear takes priority over increment.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)       pkt_count <= '0;
    else if (clear)            pkt_count <= '0;
    else if (pop && data_last) pkt_count <= pkt_count + C_PKT_CNT_WIDTH'(1);
  end

  // Sticky partial-strobe flag; a new error takes priority over clear.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)                          strb_error <= 1'b0;
    else if (push && (S_AXIS_TSTRB != STRB_ONES)) strb_error <= 1'b1;
    else if (clear)                               strb_error <= 1'b0;
  end

endmodule
